// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between the accumulation logic and the bit-serial adder sequencer.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, opA, opB, cin,
        input  busy, done, sum, cout
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, opA, opB, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder sequencer sharing one external full_adder cell, LSB first.
// Define SERIAL_ADD_SUB_EN to add the subtract-select input (a - b via ~b and carry-in 1).
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus,
    output logic             o_faA,
    output logic             o_faB,
    output logic             o_faC,
    input  logic             i_faS,
    input  logic             i_faCout
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT         r_state;
    stateT         w_next;
    logic [W-1:0]  r_aSh;
    logic [W-1:0]  r_bSh;
    logic [W-2:0]  r_sSh;
    logic          r_cReg;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          w_sub;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The adder cell only sees live operand bits during RUN; it is parked at 0 otherwise.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        o_faA    = 1'b0;
        o_faB    = 1'b0;
        o_faC    = 1'b0;
        case (r_state)
            RUN: begin
                bus.busy = 1'b1;
                o_faA    = r_aSh[0];
                o_faB    = r_bSh[0];
                o_faC    = r_cReg;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Sum bits enter at the top of a W-1 bit shifter; the last bit comes straight from the cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aSh  <= '0;
            r_bSh  <= '0;
            r_sSh  <= '0;
            r_cReg <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_aSh  <= bus.opA;
                        r_bSh  <= w_sub ? ~bus.opB : bus.opB;
                        r_cReg <= w_sub ? 1'b1 : bus.cin;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_sSh  <= (r_sSh >> 1) | ((W-1)'(i_faS) << (W - 2));
                    r_aSh  <= r_aSh >> 1;
                    r_bSh  <= r_bSh >> 1;
                    r_cReg <= i_faCout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum  <= {i_faS, r_sSh};
                        r_cout <= i_faCout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at W=8 and W=2, each with its own full_adder model.
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
    localparam int W  = 8;
    localparam int W2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic faA, faB, faC, faS, faCout;
    logic fa2A, fa2B, fa2C, fa2S, fa2Cout;

    serial_add_ctrl_if #(.W(W))  bus  ();
    serial_add_ctrl_if #(.W(W2)) bus2 ();

    serial_add_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_faA(faA), .o_faB(faB), .o_faC(faC), .i_faS(faS), .i_faCout(faCout)
    );

    serial_add_ctrl #(.W(W2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .o_faA(fa2A), .o_faB(fa2B), .o_faC(fa2C), .i_faS(fa2S), .i_faCout(fa2Cout)
    );

    // External full_adder cells
    assign faS     = faA ^ faB ^ faC;
    assign faCout  = (faA & faB) | (faC & (faA ^ faB));
    assign fa2S    = fa2A ^ fa2B ^ fa2C;
    assign fa2Cout = (fa2A & fa2B) | (fa2C & (fa2A ^ fa2B));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expVal);
        total++;
        if (got !== expVal) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, expVal, $time);
        end
    endtask

    // One W=8 operation from the IDLE cycle through the idle cycle after done.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci,
                                 input logic sb, input logic pulseAgain, input logic [8:0] expRes);
        logic [7:0] aw;
        logic [7:0] bw;
        logic       carry;
        aw    = a;
        bw    = sb ? ~b : b;
        carry = sb ? 1'b1 : ci;
        @(negedge clk);
        bus.start = 1'b1;
        bus.opA   = a;
        bus.opB   = b;
        bus.cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = sb;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.opA   = ~a;
        bus.opB   = ~b;
        bus.cin   = ~ci;
        for (int k = 1; k <= W + 1; k++) begin
            if (pulseAgain && k == 2) bus.start = 1'b1;
            if (pulseAgain && k == 3) bus.start = 1'b0;
            checkOutput("busy", 32'(bus.busy), 32'd1);
            checkOutput("done", 32'(bus.done), 32'(k == W + 1));
            if (k <= W) begin
                checkOutput("faA", 32'(faA), 32'(aw[0]));
                checkOutput("faB", 32'(faB), 32'(bw[0]));
                checkOutput("faC", 32'(faC), 32'(carry));
                carry = (aw[0] & bw[0]) | (carry & (aw[0] ^ bw[0]));
                aw    = aw >> 1;
                bw    = bw >> 1;
                @(negedge clk);
            end else begin
                checkOutput("sum",  32'(bus.sum),  32'(expRes[7:0]));
                checkOutput("cout", 32'(bus.cout), 32'(expRes[8]));
                checkOutput("faIdleDone", 32'({faA, faB, faC}), 32'd0);
            end
        end
        @(negedge clk);
        checkOutput("busyAfter", 32'(bus.busy), 32'd0);
        checkOutput("doneAfter", 32'(bus.done), 32'd0);
        checkOutput("sumHold",   32'({bus.cout, bus.sum}), 32'(expRes));
        bus.start = 1'b0;
    endtask

    // One W=2 operation: done is expected three edges after the start edge counting it.
    task automatic applyStimulusNarrow(input logic [1:0] a, input logic [1:0] b, input logic ci,
                                       input logic [2:0] expRes);
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.opA   = a;
        bus2.opB   = b;
        bus2.cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
        bus2.sub   = 1'b0;
`endif
        @(negedge clk);
        bus2.start = 1'b0;
        checkOutput("n.busy", 32'(bus2.busy), 32'd1);
        checkOutput("n.faA",  32'(fa2A), 32'(a[0]));
        checkOutput("n.faB",  32'(fa2B), 32'(b[0]));
        @(negedge clk);
        checkOutput("n.done1", 32'(bus2.done), 32'd0);
        checkOutput("n.faA1",  32'(fa2A), 32'(a[1]));
        @(negedge clk);
        checkOutput("n.done", 32'(bus2.done), 32'd1);
        checkOutput("n.res",  32'({bus2.cout, bus2.sum}), 32'(expRes));
        @(negedge clk);
        checkOutput("n.idle", 32'({bus2.busy, bus2.done}), 32'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic       rs;
        logic [8:0] rexp;

        bus.start  = 1'b0; bus.opA  = '0; bus.opB  = '0; bus.cin  = 1'b0;
        bus2.start = 1'b0; bus2.opA = '0; bus2.opB = '0; bus2.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b0;
        bus2.sub = 1'b0;
`endif
        #2;
        checkOutput("rst.busy", 32'(bus.busy), 32'd0);
        checkOutput("rst.done", 32'(bus.done), 32'd0);
        checkOutput("rst.res",  32'({bus.cout, bus.sum}), 32'd0);
        checkOutput("rst.fa",   32'({faA, faB, faC}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed add vectors");
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 9'h100);
        applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 9'h100);
        applyStimulus(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 9'h007);

        $display("[TB] start while busy is ignored");
        applyStimulus(8'h21, 8'h13, 1'b1, 1'b0, 1'b1, 9'h035);

        $display("[TB] asynchronous reset mid-run");
        @(negedge clk);
        bus.start = 1'b1; bus.opA = 8'hFF; bus.opB = 8'hFF; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre.faA", 32'(faA), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("ar.busy", 32'(bus.busy), 32'd0);
        checkOutput("ar.done", 32'(bus.done), 32'd0);
        checkOutput("ar.res",  32'({bus.cout, bus.sum}), 32'd0);
        checkOutput("ar.fa",   32'({faA, faB, faC}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 9'h046);
        applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 9'h101);

`ifdef SERIAL_ADD_SUB_EN
        $display("[TB] subtract vectors");
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 9'h10F);
        applyStimulus(8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 9'h0FF);
`endif

        $display("[TB] random W=8 operations");
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`endif
            if (rs) rexp = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
            else    rexp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            applyStimulus(ra, rb, rc, rs, 1'b0, rexp);
        end

        $display("[TB] exhaustive W=2 operations");
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    applyStimulusNarrow(2'(a), 2'(b), 1'(c), 3'(a + b + c));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
